// File: rtl/rx_tx_fifo.sv
// rx_tx_fifo: byte FIFO between UART receiver and transmitter in the echo path.
// Captures every received byte, buffers up to 2^DEPTH_LOG2 entries, and launches
// them one at a time into the transmitter with a start/busy handshake.
module rx_tx_fifo #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_W-1:0]     rx_data_i,
    input  logic                  rx_valid_i,
    input  logic                  tx_busy_i,
    output logic [DATA_W-1:0]     tx_data_o,
    output logic                  tx_start_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  overflow_o,
    input  logic                  overflow_clr_i
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned TMR_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [TMR_W-1:0]      TMR_LOAD = TMR_W'(ACK_TIMEOUT);
    localparam logic [TMR_W-1:0]      TMR_ONE  = TMR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_e;

    state_e                  state_q;
    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    overflow_q;
    logic [DATA_W-1:0]       tx_data_q;
    logic                    tx_start_q;
    logic [TMR_W-1:0]        timer_q;

    logic                    empty;
    logic                    full;
    logic                    pop;
    logic                    push;
    logic                    ovf_set;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);

    // Pop only on the IDLE->LAUNCH transition; a pop frees a slot for a same-cycle push even when full.
    always_comb begin
        pop     = (state_q == S_IDLE) && !empty && !tx_busy_i;
        push    = rx_valid_i && (!full || pop);
        ovf_set = rx_valid_i && full && !pop;
    end

    // Next write pointer and occupancy count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_data_i;
        end
    end

    // Write pointer, count and sticky overflow flag (set beats clear).
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Launch FSM: pops a byte, pulses start, then waits for the transmitter ack and completion.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            timer_q    <= '0;
        end else begin
            tx_start_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        tx_data_q  <= mem_q[rd_ptr_q];
                        rd_ptr_q   <= rd_ptr_q + PTR_ONE;
                        tx_start_q <= 1'b1;
                        state_q    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    timer_q <= TMR_LOAD;
                    state_q <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    // Expired ack: the byte counts as sent and is not retried.
                    if (tx_busy_i) begin
                        state_q <= S_WAIT_DONE;
                    end else if (timer_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q - TMR_ONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_start_o = tx_start_q;
    assign count_o    = count_q;
    assign empty_o    = empty;
    assign full_o     = full;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_rx_tx_fifo.sv
// Directed bench for rx_tx_fifo: a scoreboard queue holds bytes expected on the
// transmitter side; a monitor logs each tx_start pulse and the stimulus compares.
module tb_rx_tx_fifo;

    localparam int unsigned ACK_TO = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy_man;
    logic       model_en;
    logic       ovf_clr;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [4:0] count;
    logic       empty, full, ovf;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    logic [7:0] exp_q [$];
    logic [7:0] obs [256];
    int         obs_cyc [256];
    int         obs_wr = 0;
    int         obs_rd = 0;
    int         bcnt   = 0;

    always #5 clk = ~clk;

    rx_tx_fifo #(.DATA_W(8), .DEPTH_LOG2(4), .ACK_TIMEOUT(ACK_TO)) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .rx_data_i      (rx_data),
        .rx_valid_i     (rx_valid),
        .tx_busy_i      (tx_busy),
        .tx_data_o      (tx_data),
        .tx_start_o     (tx_start),
        .count_o        (count),
        .empty_o        (empty),
        .full_o         (full),
        .overflow_o     (ovf),
        .overflow_clr_i (ovf_clr)
    );

    // Transmitter model: busy for 20 cycles after each start when enabled.
    assign tx_busy = model_en ? (bcnt != 0) : busy_man;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_start === 1'b1) bcnt <= 20;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end

    // Start monitor: log byte and cycle of every launch pulse.
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            obs[obs_wr]     <= tx_data;
            obs_cyc[obs_wr] <= cyc;
            obs_wr          <= obs_wr + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a run of bytes on consecutive cycles; accepted ones go to the scoreboard.
    task automatic push_run(input logic [7:0] first, input int n, input int n_accept);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_data  = first + 8'(i);
            rx_valid = 1'b1;
            if (i < n_accept) exp_q.push_back(first + 8'(i));
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic expect_starts(input int n);
        logic [31:0] e;
        for (int i = 0; i < n; i++) begin
            int w = 0;
            while (obs_wr == obs_rd && w < 400) begin
                @(negedge clk);
                w++;
            end
            check("start_seen", 32'(obs_wr != obs_rd), 32'd1);
            if (obs_wr != obs_rd) begin
                e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
                check("tx_byte", 32'(obs[obs_rd]), e);
                obs_rd++;
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        busy_man = 1'b0;
        model_en = 1'b0;
        ovf_clr  = 1'b0;

        // Reset values before any clock edge.
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(2);

        // Single byte, busy held low.
        @(negedge clk);
        rx_data = 8'hA5; rx_valid = 1'b1;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        rx_valid = 1'b0;
        check("single_count1", 32'(count), 32'd1);
        check("single_nostart_yet", 32'(tx_start), 32'd0);
        @(negedge clk);
        check("single_start", 32'(tx_start), 32'd1);
        check("single_data", 32'(tx_data), 32'hA5);
        check("single_count0", 32'(count), 32'd0);
        @(negedge clk);
        check("single_start_low", 32'(tx_start), 32'd0);
        expect_starts(1);
        wait_cyc(25);
        check("single_once", 32'(obs_wr - obs_rd), 32'd0);

        // Burst ordering with the transmitter model.
        model_en = 1'b1;
        push_run(8'h01, 5, 5);
        expect_starts(5);
        check("burst_gap", 32'((obs_cyc[obs_rd-1] - obs_cyc[obs_rd-2]) >= 3), 32'd1);
        check("burst_ovf", 32'(ovf), 32'd0);
        wait_cyc(30);

        // Overflow: 17 bytes into 16 slots with busy held.
        model_en = 1'b0; busy_man = 1'b1;
        push_run(8'h10, 17, 16);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_flag", 32'(ovf), 32'd1);
        @(negedge clk);
        model_en = 1'b1;
        expect_starts(16);
        wait_cyc(30);
        check("ovf_no_extra", 32'(obs_wr - obs_rd), 32'd0);
        check("ovf_drained", 32'(empty), 32'd1);
        check("ovf_sticky", 32'(ovf), 32'd1);
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);

        // Full with push on the pop cycle.
        model_en = 1'b0; busy_man = 1'b1;
        push_run(8'h30, 16, 16);
        check("pp_full", 32'(full), 32'd1);
        @(negedge clk);
        model_en = 1'b1;
        rx_data = 8'h77; rx_valid = 1'b1;
        exp_q.push_back(8'h77);
        @(negedge clk);
        rx_valid = 1'b0;
        check("pp_count", 32'(count), 32'd16);
        check("pp_ovf", 32'(ovf), 32'd0);
        check("pp_popped", 32'(tx_start), 32'd1);
        expect_starts(17);
        wait_cyc(30);

        // Ack timeout: busy never rises.
        model_en = 1'b0; busy_man = 1'b0;
        push_run(8'hC1, 2, 2);
        expect_starts(2);
        check("timeout_gap", 32'(obs_cyc[obs_rd-1] - obs_cyc[obs_rd-2]), 32'(ACK_TO + 3));
        wait_cyc(25);

        // Async reset in WAIT_DONE with three bytes stored.
        @(negedge clk); rx_data = 8'hD1; rx_valid = 1'b1;
        exp_q.push_back(8'hD1);
        @(negedge clk); rx_data = 8'hD2;
        @(negedge clk); rx_data = 8'hD3; busy_man = 1'b1;
        @(negedge clk); rx_data = 8'hD4;
        @(negedge clk); rx_valid = 1'b0;
        check("ar_count3", 32'(count), 32'd3);
        expect_starts(1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_count", 32'(count), 32'd0);
        check("ar_empty", 32'(empty), 32'd1);
        check("ar_start", 32'(tx_start), 32'd0);
        check("ar_data", 32'(tx_data), 32'd0);
        check("ar_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        busy_man = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(25);
        check("ar_no_start", 32'(obs_wr - obs_rd), 32'd0);
        push_run(8'hE7, 1, 1);
        expect_starts(1);
        wait_cyc(25);
        check("end_no_extra", 32'(obs_wr - obs_rd), 32'd0);
        check("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
